// File: rtl/i2c_slave_ctrl_keyed.sv
// i2c_slave_ctrl_keyed: I2C slave control FSM that steers the leading write bytes to the DES key register and later bytes to the RX FIFO
// Inputs : clk, n_rst, start_found/stop_found, byte_received, ack_prep/check_ack/ack_done, rw_mode, address_match, sda_in, rx_full, tx_empty
// Outputs: rx_enable, tx_enable, read_enable, write_enable, key_write, byte_index, sda_mode, load_data, i2c_rw, rx_overflow, tx_underrun, busy
module i2c_slave_ctrl_keyed #(
  parameter int KEY_BYTES    = 24,
  parameter int IDX_W        = 5,
  parameter int RX_FULL_NACK = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start_found,
  input  logic             stop_found,
  input  logic             byte_received,
  input  logic             ack_prep,
  input  logic             check_ack,
  input  logic             ack_done,
  input  logic             rw_mode,
  input  logic             address_match,
  input  logic             sda_in,
  input  logic             rx_full,
  input  logic             tx_empty,
  output logic             rx_enable,
  output logic             tx_enable,
  output logic             read_enable,
  output logic             write_enable,
  output logic             key_write,
  output logic [IDX_W-1:0] byte_index,
  output logic [1:0]       sda_mode,
  output logic             load_data,
  output logic             i2c_rw,
  output logic             rx_overflow,
  output logic             tx_underrun,
  output logic             busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR_RX, ADDR_CHK, ACK_WAIT, ACK_DRIVE, DATA_RX,
    STORE, TX_LOAD, TX_SEND, MACK_WAIT, MACK_HOLD, DONE
  } state_t;
  localparam logic [IDX_W-1:0] KEY_IDX = IDX_W'(KEY_BYTES);
  state_t state, next;
  logic nack, rx_full_q, tx_empty_q, is_key;
  // FIFO flags are registered so the store/load pulses stay Moore outputs;
  // the value seen in STORE/TX_LOAD is the flag from the triggering cycle.
  assign is_key = byte_index < KEY_IDX;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:      ;
      ADDR_RX:   if (byte_received) next = ADDR_CHK;
      ADDR_CHK:  next = address_match ? ACK_WAIT : DONE;
      ACK_WAIT:  if (ack_prep) next = ACK_DRIVE;
      ACK_DRIVE: if (ack_done) next = nack ? DONE : i2c_rw ? TX_LOAD : DATA_RX;
      DATA_RX:   if (byte_received) next = STORE;
      STORE:     next = ACK_WAIT;
      TX_LOAD:   next = TX_SEND;
      TX_SEND:   if (ack_prep) next = MACK_WAIT;
      MACK_WAIT: if (check_ack) next = sda_in ? DONE : MACK_HOLD;
      MACK_HOLD: if (ack_done) next = TX_LOAD;
      DONE:      ;
      default:   next = IDLE;
    endcase
    if (stop_found) next = IDLE;
    else if (start_found) next = ADDR_RX;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      nack       <= 1'b0;
      byte_index <= '0;
      i2c_rw     <= 1'b0;
      rx_full_q  <= 1'b0;
      tx_empty_q <= 1'b0;
    end else begin
      rx_full_q  <= rx_full;
      tx_empty_q <= tx_empty;
      if (start_found) begin
        byte_index <= '0;
        nack       <= 1'b0;
      end else if (!stop_found) begin
        if (state == ADDR_CHK && address_match) begin
          i2c_rw <= rw_mode;
          nack   <= 1'b0;
        end
        if (state == STORE && is_key) byte_index <= byte_index + IDX_W'(1);
        if (state == STORE && !is_key && rx_full_q && RX_FULL_NACK != 0) nack <= 1'b1;
      end
    end
  always_comb begin
    rx_enable    = state == ADDR_RX || state == DATA_RX;
    tx_enable    = state == TX_SEND;
    load_data    = state == TX_LOAD;
    read_enable  = state == TX_LOAD && !tx_empty_q;
    tx_underrun  = state == TX_LOAD && tx_empty_q;
    key_write    = state == STORE && is_key;
    write_enable = state == STORE && !is_key && !rx_full_q;
    rx_overflow  = state == STORE && !is_key && rx_full_q && RX_FULL_NACK == 0;
    sda_mode     = state == ACK_DRIVE ? (nack ? 2'b10 : 2'b01) : state == TX_SEND ? 2'b11 : 2'b00;
    busy         = state != IDLE;
  end
endmodule
